fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder and supplies its 32-bit `instr` input. It owns the program counter and issues single-outstanding requests to instruction memory. Returned words are buffered with their PC in a 2-entry FIFO, and the FIFO head is presented to decode through a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and discard any in-flight response.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// buffers returned words in a 2-entry FIFO and hands them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_FAULT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_fault;

    logic        w_pop;
    logic        w_redirect;
    logic        w_misaligned;
    logic        w_rvalid;
    logic        w_tail;
    logic [31:0] w_pc_inc;
    logic [1:0]  w_count_popped;
    logic [1:0]  w_count_pushed;

    assign w_pop          = (r_count != 2'd0) && instr_ready;
    assign w_redirect     = redirect_valid && (r_state != S_FAULT);
    assign w_misaligned   = (redirect_pc[1:0] != 2'b00);
    assign w_rvalid       = imem_rvalid && imem_req;
    assign w_tail         = r_head ^ r_count[0];
    assign w_pc_inc       = r_pc + 32'd4;
    assign w_count_popped = r_count - {1'b0, w_pop};
    assign w_count_pushed = r_count + 2'd1 - {1'b0, w_pop};

    assign imem_req    = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign imem_addr   = r_addr;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = instr_valid ? r_fifo_instr[r_head] : NOP_INSTR;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_head] : 32'h0;
    assign fetch_fault = r_fault;

    // r_addr only moves when a new transaction starts, so it stays stable
    // for the whole of WAIT and keeps the abandoned address through DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_pc            <= RESET_PC;
            r_addr          <= RESET_PC;
            r_count         <= 2'd0;
            r_head          <= 1'b0;
            r_fault         <= 1'b0;
            r_fifo_pc[0]    <= 32'h0;
            r_fifo_pc[1]    <= 32'h0;
            r_fifo_instr[0] <= 32'h0;
            r_fifo_instr[1] <= 32'h0;
        end else if (w_redirect) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            if (w_misaligned) begin
                r_fault <= 1'b1;
                r_state <= (r_state != S_IDLE && !w_rvalid) ? S_DRAIN : S_FAULT;
            end else begin
                r_pc <= redirect_pc;
                if (r_state == S_IDLE || w_rvalid) begin
                    r_state <= S_WAIT;
                    r_addr  <= redirect_pc;
                end else begin
                    r_state <= S_DRAIN;
                end
            end
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case (r_state)
                S_IDLE: begin
                    r_count <= w_count_popped;
                    if (r_count < 2'd2) begin
                        r_state <= S_WAIT;
                        r_addr  <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (w_rvalid) begin
                        r_fifo_pc[w_tail]    <= r_pc;
                        r_fifo_instr[w_tail] <= imem_rdata;
                        r_pc                 <= w_pc_inc;
                        r_count              <= w_count_pushed;
                        if (w_count_pushed < 2'd2) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_count <= w_count_popped;
                    end
                end
                S_DRAIN: begin
                    r_count <= w_count_popped;
                    if (w_rvalid) begin
                        r_state <= r_fault ? S_FAULT : S_WAIT;
                        r_addr  <= r_pc;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a vector table for
// redirect/fault behaviour, and randomized traffic against an in-order stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic        imemReq, instrValid, fetchFault;
    logic [31:0] imemAddr, instrWord, instrPc;
    logic        wrapReq, wrapValid, wrapFault;
    logic [31:0] wrapAddr, wrapInstr, wrapInstrPc;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          memLatency = 1;
    int          memAge = 0;
    bit          memBusy = 0;
    logic [31:0] memAddr = 32'h0;
    logic [31:0] expPc = 32'h0;
    bit          monitorOn = 0;
    int          pops = 0;

    typedef struct {
        logic [31:0] target;
        int          delay;
        logic        expReqA;
        logic [31:0] expAddrA;
        logic        expFault;
        logic        expReqB;
        logic [31:0] expAddrB;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imemReq), .imem_addr(imemAddr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instrValid), .instr_ready(instr_ready),
        .instr(instrWord), .instr_pc(instrPc), .fetch_fault(fetchFault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(wrapReq), .imem_addr(wrapAddr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(wrapValid), .instr_ready(instr_ready),
        .instr(wrapInstr), .instr_pc(wrapInstrPc), .fetch_fault(wrapFault)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One clock: the stream model checks any pop, then the memory model
    // answers each transaction memLatency cycles after it starts with addr+0x100.
    task automatic tick();
        bit redirNow;
        redirNow = redirect_valid;
        if (monitorOn && instrValid && instr_ready) begin
            checkOutput("popPc", instrPc, expPc);
            checkOutput("popInstr", instrWord, expPc + 32'h100);
            expPc = expPc + 32'd4;
            pops++;
        end
        if (redirect_valid) expPc = redirect_pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (redirNow) checkOutput("validAfterRedirect", {31'b0, instrValid}, 32'h0);
        if (!imemReq) begin
            memBusy = 0;
        end else if (!memBusy || imem_rvalid) begin
            memBusy = 1;
            memAge  = 0;
            memAddr = imemAddr;
        end else begin
            memAge++;
            checkOutput("addrStable", imemAddr, memAddr);
        end
        imem_rvalid = memBusy && (memAge >= memLatency);
        imem_rdata  = imem_rvalid ? imemAddr + 32'h100 : 32'hDEAD_BEEF;
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        memBusy        = 0;
        memAge         = 0;
        expPc          = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("resetReq", {31'b0, imemReq}, 32'h0);
        checkOutput("resetValid", {31'b0, instrValid}, 32'h0);
        checkOutput("resetInstr", instrWord, 32'h0000_0013);
        checkOutput("resetInstrPc", instrPc, 32'h0);
        checkOutput("resetFault", {31'b0, fetchFault}, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("idleAfterRelease", {31'b0, imemReq}, 32'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        doReset();
        memLatency = 3;
        monitorOn  = 0;
        tick();
        repeat (v.delay) tick();
        redirect_valid = 1'b1;
        redirect_pc    = v.target;
        tick();
        checkOutput("vecFaultA", {31'b0, fetchFault}, {31'b0, v.expFault});
        checkOutput("vecReqA", {31'b0, imemReq}, {31'b0, v.expReqA});
        if (v.expReqA) checkOutput("vecAddrA", imemAddr, v.expAddrA);
        repeat (2) tick();
        checkOutput("vecReqB", {31'b0, imemReq}, {31'b0, v.expReqB});
        checkOutput("vecFaultB", {31'b0, fetchFault}, {31'b0, v.expFault});
        if (v.expReqB) checkOutput("vecAddrB", imemAddr, v.expAddrB);
        if (v.expFault) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h100;
            tick();
            checkOutput("faultIgnoresRedirect", {31'b0, imemReq}, 32'h0);
            tick();
            checkOutput("faultStillIdle", {31'b0, imemReq}, 32'h0);
            checkOutput("faultNoValid", {31'b0, instrValid}, 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        int popsBefore;
        logic [31:0] r;

        vecs[0] = '{32'h0000_0040, 1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0040};
        vecs[1] = '{32'h0000_0022, 1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h0000_0041, 3, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFC, 3, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC};

        // Streaming with a 1-cycle memory, plus the wrapping instance alongside.
        doReset();
        memLatency  = 1;
        instr_ready = 1'b1;
        monitorOn   = 1;
        pops        = 0;
        tick();
        checkOutput("firstReq", {31'b0, imemReq}, 32'h1);
        checkOutput("firstAddr", imemAddr, 32'h0);
        checkOutput("wrapFirstAddr", wrapAddr, 32'hFFFF_FFFC);
        checkOutput("wrapFirstReq", {31'b0, wrapReq}, 32'h1);
        tick();
        tick();
        checkOutput("wrapSecondAddr", wrapAddr, 32'h0000_0000);
        checkOutput("wrapValid", {31'b0, wrapValid}, 32'h1);
        checkOutput("wrapHeadPc", wrapInstrPc, 32'hFFFF_FFFC);
        checkOutput("wrapHeadInstr", wrapInstr, 32'h0000_0100);
        checkOutput("wrapNoFault", {31'b0, wrapFault}, 32'h0);
        repeat (37) tick();
        checkOutput("streamPops", pops, 32'd19);

        // Backpressure: two words held, no further requests, drained in order.
        instr_ready = 1'b0;
        repeat (10) tick();
        checkOutput("bpReqIdle", {31'b0, imemReq}, 32'h0);
        checkOutput("bpValid", {31'b0, instrValid}, 32'h1);
        checkOutput("bpHeadPc", instrPc, expPc);
        instr_ready = 1'b1;
        popsBefore  = pops;
        tick();
        checkOutput("bpSecondValid", {31'b0, instrValid}, 32'h1);
        tick();
        checkOutput("bpDrained", pops, popsBefore + 2);
        repeat (6) tick();

        // Redirect one cycle into a 3-cycle request to address 8.
        doReset();
        memLatency  = 3;
        instr_ready = 1'b1;
        monitorOn   = 1;
        guard = 0;
        while (guard < 100 && !(imemReq && imemAddr == 32'h8 && memAge == 0)) begin
            tick();
            guard++;
        end
        checkOutput("reachAddr8", {31'b0, (guard < 100)}, 32'h1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        checkOutput("drainReq", {31'b0, imemReq}, 32'h1);
        checkOutput("drainAddrHeld", imemAddr, 32'h8);
        guard = 0;
        while (guard < 10 && !imem_rvalid) begin
            tick();
            guard++;
        end
        checkOutput("drainRvalidSeen", {31'b0, (guard < 10)}, 32'h1);
        tick();
        checkOutput("postDrainReq", {31'b0, imemReq}, 32'h1);
        checkOutput("postDrainAddr", imemAddr, 32'h40);
        checkOutput("postDrainEmpty", {31'b0, instrValid}, 32'h0);
        repeat (20) tick();

        // Redirect coinciding with rvalid and a pop.
        doReset();
        memLatency  = 1;
        instr_ready = 1'b0;
        monitorOn   = 1;
        guard = 0;
        while (guard < 20 && !(instrValid && imem_rvalid)) begin
            tick();
            guard++;
        end
        checkOutput("simulSetup", {31'b0, (guard < 20)}, 32'h1);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        checkOutput("simulReq", {31'b0, imemReq}, 32'h1);
        checkOutput("simulAddr", imemAddr, 32'h80);
        for (int i = 0; i < 20; i++) begin
            instr_ready = ($urandom_range(0, 1) == 1);
            tick();
        end

        // Redirect vectors, including misaligned targets and fault stickiness.
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Randomized traffic against the in-order stream model.
        doReset();
        monitorOn = 1;
        pops      = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) memLatency = $urandom_range(1, 3);
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                r = $urandom();
                redirect_valid = 1'b1;
                redirect_pc    = {r[31:2], 2'b00};
            end
            tick();
        end
        checkOutput("randomProgress", {31'b0, (pops >= 20)}, 32'h1);
        checkOutput("randomNoFault", {31'b0, fetchFault}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
